noise_est_stream_ctrl: RTL and testbench

Sequencer between the noise-estimation AXI read master and `noise_estimation`. It turns accepted AXI read-data beats (one RGB pixel per beat, one burst per block row) into a registered 8-bit luminance pixel stream. It attaches block and frame framing to that stream (`start_data`, `start_of_frame`, `block_last`), so the estimator no longer needs a gated clock or externally timed strobes. It closes the frame when the estimator reports `estimated_noise_ready`.

---
 rtl/noise_est_stream_ctrl.sv | 144 ++++++++++++++
 tb/tb_noise_est_stream_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_est_stream_ctrl.sv
// Sequencer between the noise-estimation AXI read master and the estimator.
// Converts RGB read beats into a framed, registered luminance pixel stream.
module noise_est_stream_ctrl #(
   parameter int DATA_WIDTH      = 32,
   parameter int BYTE_DATA_WIDTH = 8,
   parameter int BLOCK_SIZE      = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       frame_ready,
   input  logic [31:0]                blocks_per_frame,
   input  logic [DATA_WIDTH-1:0]      rdata,
   input  logic                       rvalid,
   input  logic                       rready,
   input  logic                       rlast,
   input  logic                       estimated_noise_ready,
   output logic [BYTE_DATA_WIDTH-1:0] pix_data,
   output logic                       pix_valid,
   output logic                       start_data,
   output logic                       start_of_frame,
   output logic                       block_last,
   output logic                       frame_done,
   output logic                       busy,
   output logic                       err_burst
);

   localparam int B  = BYTE_DATA_WIDTH;
   localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      WAIT_EST,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [CW-1:0] row;
   logic [31:0]   blk;
   logic [31:0]   total;

   logic [B-1:0] r;
   logic [B-1:0] g;
   logic [B-1:0] b;
   logic [B+1:0] sum;
   logic [B+1:0] mean;
   logic         acc;
   logic         col_last;
   logic         row_last;
   logic         blk_last;
   logic         unused_pad;

   // Channel extraction, RGB mean and row/block position decode
   always_comb begin
      r        = rdata[3*B-1:2*B];
      g        = rdata[2*B-1:B];
      b        = rdata[B-1:0];
      sum      = {2'b00, r} + {2'b00, g} + {2'b00, b};
      mean     = sum / (B+2)'(3);
      acc      = rvalid & rready & (state == STREAM);
      col_last = (col == LAST);
      row_last = (row == LAST);
      blk_last = (blk == total - 32'd1);
   end

   assign unused_pad = ^rdata[DATA_WIDTH-1:3*B];

   // Frame FSM, beat counters and registered pixel/framing outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         col            <= '0;
         row            <= '0;
         blk            <= '0;
         total          <= '0;
         pix_data       <= '0;
         pix_valid      <= 1'b0;
         start_data     <= 1'b0;
         start_of_frame <= 1'b0;
         block_last     <= 1'b0;
         frame_done     <= 1'b0;
         busy           <= 1'b0;
         err_burst      <= 1'b0;
      end else begin
         pix_valid      <= 1'b0;
         start_data     <= 1'b0;
         start_of_frame <= 1'b0;
         block_last     <= 1'b0;
         frame_done     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_ready) begin
                  busy <= 1'b1;
                  if (blocks_per_frame != 32'd0) begin
                     state     <= STREAM;
                     total     <= blocks_per_frame;
                     err_burst <= 1'b0;
                     col       <= '0;
                     row       <= '0;
                     blk       <= '0;
                  end else begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (acc) begin
                  pix_valid      <= 1'b1;
                  pix_data       <= mean[B-1:0];
                  start_data     <= (col == '0) && (row == '0);
                  start_of_frame <= (col == '0) && (row == '0) &&
                                    (blk == 32'd0);
                  block_last     <= col_last && row_last;
                  if (rlast != col_last)
                     err_burst <= 1'b1;
                  col <= col_last ? '0 : col + 1'b1;
                  if (col_last)
                     row <= row_last ? '0 : row + 1'b1;
                  if (col_last && row_last) begin
                     blk <= blk + 32'd1;
                     if (blk_last)
                        state <= WAIT_EST;
                  end
               end
            end
            WAIT_EST: begin
               if (estimated_noise_ready) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noise_est_stream_ctrl.sv
// Directed bench for noise_est_stream_ctrl with a pixel scoreboard.
// Expected pixels are queued when beats are driven, popped on pix_valid.
module tb_noise_est_stream_ctrl;

   typedef struct packed {
      logic [7:0] pix;
      logic       sd;
      logic       sof;
      logic       bl;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_ready = 1'b0;
   logic [31:0] blocks_per_frame = '0;
   logic [31:0] rdata = '0;
   logic        rvalid = 1'b0;
   logic        rready = 1'b0;
   logic        rlast = 1'b0;
   logic        estimated_noise_ready = 1'b0;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        start_data;
   logic        start_of_frame;
   logic        block_last;
   logic        frame_done;
   logic        busy;
   logic        err_burst;

   int   checks = 0;
   int   failures = 0;
   int   pidx = 0;
   int   npix = 0;
   exp_t q[$];

   noise_est_stream_ctrl #(
      .DATA_WIDTH(32),
      .BYTE_DATA_WIDTH(8),
      .BLOCK_SIZE(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .frame_ready(frame_ready),
      .blocks_per_frame(blocks_per_frame),
      .rdata(rdata),
      .rvalid(rvalid),
      .rready(rready),
      .rlast(rlast),
      .estimated_noise_ready(estimated_noise_ready),
      .pix_data(pix_data),
      .pix_valid(pix_valid),
      .start_data(start_data),
      .start_of_frame(start_of_frame),
      .block_last(block_last),
      .frame_done(frame_done),
      .busy(busy),
      .err_burst(err_burst)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: pop one expected pixel per pix_valid
   always @(negedge clk) begin : mon
      exp_t e;
      exp_t gv;
      if (rst_n) begin
         if (pix_valid) begin
            gv = '{pix_data, start_data, start_of_frame, block_last};
            checks++;
            assert (q.size() != 0) else begin
               failures++;
               $error("FAIL extra_pixel got=%0h exp=none", gv);
            end
            if (q.size() != 0) begin
               e = q.pop_front();
               checks++;
               assert (gv === e) else begin
                  failures++;
                  $error("FAIL pixel%0d got=%0h exp=%0h", npix, gv, e);
               end
            end
            npix++;
         end else begin
            checks++;
            assert ({start_data, start_of_frame, block_last} === 3'b000)
            else begin
               failures++;
               $error("FAIL strobe_no_valid got=%b exp=000",
                      {start_data, start_of_frame, block_last});
            end
         end
      end
   end

   task automatic start_frame(input logic [31:0] n);
      npix = 0;
      pidx = 0;
      blocks_per_frame = n;
      frame_ready = 1'b1;
      @(posedge clk);
      #1;
      frame_ready = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input bit last,
                            input bit rdy, input logic [7:0] ep);
      exp_t e;
      rdata  = d;
      rvalid = 1'b1;
      rready = rdy;
      rlast  = last;
      if (rdy) begin
         e.pix = ep;
         e.sd  = (pidx % 64 == 0);
         e.sof = (pidx == 0);
         e.bl  = (pidx % 64 == 63);
         q.push_back(e);
         pidx++;
      end
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      rready = 1'b0;
      rlast  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (frame_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   task automatic pulse_est();
      estimated_noise_ready = 1'b1;
      @(posedge clk);
      #1;
      estimated_noise_ready = 1'b0;
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
      chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      chk({tag, "_strobes"},
          32'({start_data, start_of_frame, block_last}), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_err_burst"}, 32'(err_burst), 32'd0);
   endtask

   initial begin
      logic [7:0]  p8;
      logic [31:0] d;
      logic [7:0]  ep;
      int          accepted;
      int          step;
      int          s;
      bit          rdy;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      outputs_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Frame A: 4 blocks, ramp data, est ready / frame_ready ignored
      start_frame(32'd4);
      chk("A_busy", 32'(busy), 32'd1);
      chk("A_err_clear", 32'(err_burst), 32'd0);
      for (int p = 0; p < 256; p++) begin
         p8 = 8'(p);
         if (p == 10) estimated_noise_ready = 1'b1;
         if (p == 50) begin
            frame_ready = 1'b1;
            blocks_per_frame = 32'd1;
         end
         send_beat({8'h00, p8, p8, p8}, (p % 8 == 7), 1'b1, p8);
         estimated_noise_ready = 1'b0;
         frame_ready = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("A_wait_busy", 32'(busy), 32'd1);
      chk("A_wait_nodone", 32'(frame_done), 32'd0);
      chk("A_npix", 32'(npix), 32'd256);
      chk("A_queue_empty", 32'(q.size()), 32'd0);
      pulse_est();
      wait_done("A");
      chk("A_err_end", 32'(err_burst), 32'd0);

      // Frame B: arithmetic vectors, rready toggling, misplaced rlast
      start_frame(32'd4);
      accepted = 0;
      step = 0;
      while (accepted < 256) begin
         rdy = (step % 2 == 0);
         d = 32'h0;
         ep = 8'h0;
         if (rdy) begin
            if (accepted == 0) begin
               d = 32'h000A141F;
               ep = 8'd20;
            end else if (accepted == 1) begin
               d = 32'h00FFFFFF;
               ep = 8'd255;
            end else if (accepted == 2) begin
               d = 32'hFF000000;
               ep = 8'd0;
            end else begin
               d = $urandom;
               s = int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
               ep = 8'(s / 3);
            end
            if (accepted == 43)
               chk("B_err_before", 32'(err_burst), 32'd0);
            if (accepted == 44)
               chk("B_err_after", 32'(err_burst), 32'd1);
            send_beat(d, (accepted % 8 == 7) || (accepted == 43),
                      1'b1, ep);
            accepted++;
         end else begin
            send_beat(32'h00123456, 1'b0, 1'b0, 8'h0);
         end
         step++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("B_npix", 32'(npix), 32'd256);
      chk("B_queue_empty", 32'(q.size()), 32'd0);
      pulse_est();
      wait_done("B");
      chk("B_err_held", 32'(err_burst), 32'd1);

      // Zero-block frame, then frame_ready during DONE is dropped
      start_frame(32'd0);
      chk("Z_done", 32'(frame_done), 32'd1);
      chk("Z_busy", 32'(busy), 32'd1);
      blocks_per_frame = 32'd4;
      frame_ready = 1'b1;
      @(posedge clk);
      #1;
      frame_ready = 1'b0;
      chk("Z_done_drop", 32'(frame_done), 32'd0);
      chk("Z_busy_drop", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("Z_idle", 32'(busy), 32'd0);
      chk("Z_npix", 32'(npix), 32'd0);
      chk("Z_err_kept", 32'(err_burst), 32'd1);

      // Frame C: asynchronous reset at pixel 100
      start_frame(32'd2);
      chk("C_err_clear", 32'(err_burst), 32'd0);
      for (int p = 0; p < 100; p++) begin
         p8 = 8'(255 - p);
         send_beat({8'h00, p8, p8, p8}, (p % 8 == 7), 1'b1, p8);
      end
      chk("C_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      outputs_zero("async_rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("C_no_done", 32'(frame_done), 32'd0);
      chk("C_idle", 32'(busy), 32'd0);

      // Frame D: clean single-block frame after reset
      start_frame(32'd1);
      for (int p = 0; p < 64; p++) begin
         p8 = 8'(p * 3);
         send_beat({8'hA5, p8, p8, p8}, (p % 8 == 7), 1'b1, p8);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("D_npix", 32'(npix), 32'd64);
      pulse_est();
      wait_done("D");
      chk("D_err", 32'(err_burst), 32'd0);
      chk("D_queue_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
